// File: rtl/seq_mult_param_if.sv
// Handshake and result bundle for the sequential chunked multiplier.
// The master drives start/abort/operands; the slave (the multiplier) drives results and status.
interface seq_mult_param_if #(
    parameter int DATA_W  = 8,
    parameter int CHUNK_W = 4
);
    localparam int N      = (CHUNK_W > 0) ? DATA_W / CHUNK_W : 1;
    localparam int STEPS  = N * N;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic                start;
    logic                abort;
    logic [DATA_W-1:0]   dataa;
    logic [DATA_W-1:0]   datab;
    logic [2*DATA_W-1:0] product;
    logic                done;
    logic                busy;
    logic                err;
    logic [1:0]          state_out;
    logic [STEP_W-1:0]   step_out;

    modport master (
        output start, abort, dataa, datab,
        input  product, done, busy, err, state_out, step_out
    );

    modport slave (
        input  start, abort, dataa, datab,
        output product, done, busy, err, state_out, step_out
    );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential DATA_W x DATA_W unsigned multiplier: one CHUNK_W x CHUNK_W partial product
// per cycle, shifted into a 2*DATA_W accumulator over (DATA_W/CHUNK_W)^2 steps.
module seq_mult_param #(
    parameter int DATA_W  = 8,
    parameter int CHUNK_W = 4
) (
    input  logic             clk,
    input  logic             reset_a,
    seq_mult_param_if.slave  mult_if
);
    localparam int N      = (CHUNK_W > 0) ? DATA_W / CHUNK_W : 1;
    localparam int STEPS  = N * N;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    generate
        if ((CHUNK_W < 1) ? 1'b1 : ((DATA_W % CHUNK_W) != 0)) begin : g_bad_params
            $error("seq_mult_param: DATA_W must be a positive multiple of CHUNK_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10,
        S_ERR  = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;

    int unsigned         idx_i;
    int unsigned         idx_j;
    logic [CHUNK_W-1:0]  a_chunk;
    logic [CHUNK_W-1:0]  b_chunk;
    logic [2*CHUNK_W-1:0] pp;
    logic [PROD_W-1:0]   pp_shifted;
    logic                accept;

    // Step s walks the multiplicand chunks fastest: i = s mod N, j = s div N.
    always_comb begin
        idx_i      = int'(step_q) % N;
        idx_j      = int'(step_q) / N;
        a_chunk    = a_q[idx_i*CHUNK_W +: CHUNK_W];
        b_chunk    = b_q[idx_j*CHUNK_W +: CHUNK_W];
        pp         = {{CHUNK_W{1'b0}}, a_chunk} * {{CHUNK_W{1'b0}}, b_chunk};
        pp_shifted = PROD_W'(pp) << (CHUNK_W * (idx_i + idx_j));
    end

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no path infers a latch.
        state_d   = state_q;
        product_d = product_q;
        step_d    = step_q;
        a_d       = a_q;
        b_d       = b_q;
        accept    = 1'b0;

        if (mult_if.abort) begin
            state_d   = S_IDLE;
            product_d = '0;
            step_d    = '0;
        end else begin
            unique case (state_q)
                S_CALC: begin
                    if (mult_if.start) begin
                        state_d = S_ERR;
                    end else begin
                        product_d = product_q + pp_shifted;
                        if (step_q == LAST_STEP) begin
                            step_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            step_d = step_q + STEP_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (mult_if.start) accept  = 1'b1;
                    else               state_d = S_IDLE;
                end
                default: begin
                    accept = mult_if.start;
                end
            endcase

            if (accept) begin
                a_d       = mult_if.dataa;
                b_d       = mult_if.datab;
                product_d = '0;
                step_d    = '0;
                state_d   = S_CALC;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q   <= S_IDLE;
            product_q <= '0;
            step_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            state_q   <= state_d;
            product_q <= product_d;
            step_q    <= step_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    assign mult_if.product   = product_q;
    assign mult_if.step_out  = step_q;
    assign mult_if.state_out = state_q;
    assign mult_if.done      = (state_q == S_DONE);
    assign mult_if.busy      = (state_q == S_CALC);
    assign mult_if.err       = (state_q == S_ERR);
endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: default 8/4 instance plus a 16/4 instance,
// compared against plain-arithmetic products and a chunk-sum model for partial results.
module tb_seq_mult_param;
    logic clk = 1'b0;
    logic reset_a;
    always #5 clk = ~clk;

    seq_mult_param_if #(.DATA_W(8),  .CHUNK_W(4)) if8 ();
    seq_mult_param_if #(.DATA_W(16), .CHUNK_W(4)) if16 ();

    seq_mult_param #(.DATA_W(8),  .CHUNK_W(4)) u_dut8  (.clk(clk), .reset_a(reset_a), .mult_if(if8));
    seq_mult_param #(.DATA_W(16), .CHUNK_W(4)) u_dut16 (.clk(clk), .reset_a(reset_a), .mult_if(if16));

    int n_checks = 0;
    int n_fail   = 0;

    // {state_out, busy, done, err}
    localparam logic [4:0] ST_IDLE = 5'b00_000;
    localparam logic [4:0] ST_CALC = 5'b01_100;
    localparam logic [4:0] ST_DONE = 5'b10_010;
    localparam logic [4:0] ST_ERR  = 5'b11_001;

    function automatic logic [4:0] status8();
        return {if8.state_out, if8.busy, if8.done, if8.err};
    endfunction

    function automatic logic [4:0] status16();
        return {if16.state_out, if16.busy, if16.done, if16.err};
    endfunction

    // Sum of the first k chunk products, straight from the step mapping definition.
    function automatic longint unsigned model_partial(input longint unsigned a, input longint unsigned b,
                                                      input int dw, input int cw, input int k);
        longint unsigned acc = 0;
        longint unsigned mask = (64'd1 << cw) - 1;
        int n = dw / cw;
        for (int s = 0; s < k; s++) begin
            int i = s % n;
            int j = s / n;
            acc += (((a >> (i*cw)) & mask) * ((b >> (j*cw)) & mask)) << ((i + j) * cw);
        end
        return acc;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_done8(input bit scramble, output int busy_cycles, output bit ok);
        busy_cycles = 0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (if8.done) begin
                ok = 1'b1;
                break;
            end
            if (if8.busy) busy_cycles++;
            if (scramble) begin
                if8.dataa = 8'($urandom);
                if8.datab = 8'($urandom);
            end
            cyc();
        end
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input bit scramble,
                           output logic [15:0] p, output int busy_cycles, output bit ok);
        if8.dataa = a;
        if8.datab = b;
        if8.start = 1'b1;
        cyc();
        if8.start = 1'b0;
        wait_done8(scramble, busy_cycles, ok);
        p = if8.product;
    endtask

    task automatic run_op16(input logic [15:0] a, input logic [15:0] b,
                            output logic [31:0] p, output int busy_cycles, output bit ok);
        if16.dataa = a;
        if16.datab = b;
        if16.start = 1'b1;
        cyc();
        if16.start = 1'b0;
        if16.dataa = 16'($urandom);
        if16.datab = 16'($urandom);
        busy_cycles = 0;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (if16.done) begin
                ok = 1'b1;
                break;
            end
            if (if16.busy) busy_cycles++;
            cyc();
        end
        p = if16.product;
    endtask

    task automatic test_reset();
        n_checks++;
        if (status8() !== ST_IDLE || if8.product !== 16'h0 || if8.step_out !== 2'd0) begin
            n_fail++;
            $display("FAIL reset8: status=%b product=%h step=%0d required status=%b product=0 step=0",
                     status8(), if8.product, if8.step_out, ST_IDLE);
        end
        n_checks++;
        if (status16() !== ST_IDLE || if16.product !== 32'h0 || if16.step_out !== 4'd0) begin
            n_fail++;
            $display("FAIL reset16: status=%b product=%h step=%0d required status=%b product=0 step=0",
                     status16(), if16.product, if16.step_out, ST_IDLE);
        end
    endtask

    task automatic test_basic();
        if8.dataa = 8'hFF;
        if8.datab = 8'hFF;
        if8.start = 1'b1;
        cyc();
        if8.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (status8() !== ST_CALC || if8.step_out !== 2'(k)) begin
                n_fail++;
                $display("FAIL basic_calc[%0d]: status=%b step=%0d required status=%b step=%0d",
                         k, status8(), if8.step_out, ST_CALC, k);
            end
            cyc();
        end
        n_checks++;
        if (status8() !== ST_DONE || if8.product !== 16'hFE01 || if8.step_out !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_done: status=%b product=%h step=%0d required status=%b product=fe01 step=0",
                     status8(), if8.product, if8.step_out, ST_DONE);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if (status8() !== ST_IDLE || if8.product !== 16'hFE01) begin
                n_fail++;
                $display("FAIL basic_hold[%0d]: status=%b product=%h required status=%b product=fe01",
                         k, status8(), if8.product, ST_IDLE);
            end
        end
    endtask

    task automatic test_random8();
        logic [7:0]  a, b;
        logic [15:0] p, exp_p;
        int          bc;
        bit          ok;
        for (int t = 0; t < 24; t++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (t == 0) begin a = 8'h00; b = 8'hFF; end
            if (t == 1) begin a = 8'h01; b = 8'h01; end
            exp_p = 16'(a) * 16'(b);
            run_op8(a, b, 1'b1, p, bc, ok);
            n_checks++;
            if (!ok || p !== exp_p || bc != 4) begin
                n_fail++;
                $display("FAIL random8[%0d]: %h*%h got product=%h busy=%0d done_seen=%0d required %h busy=4",
                         t, a, b, p, bc, ok, exp_p);
            end
            cyc();
        end
    endtask

    task automatic test_wide();
        logic [15:0] a, b;
        logic [31:0] p, exp_p;
        int          bc;
        bit          ok;
        for (int t = 0; t < 6; t++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (t == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
            if (t == 1) begin a = 16'h1234; b = 16'h0010; end
            exp_p = 32'(a) * 32'(b);
            run_op16(a, b, p, bc, ok);
            n_checks++;
            if (!ok || p !== exp_p || bc != 16 || status16() !== ST_DONE) begin
                n_fail++;
                $display("FAIL wide[%0d]: %h*%h got product=%h busy=%0d done_seen=%0d required %h busy=16",
                         t, a, b, p, bc, ok, exp_p);
            end
            cyc();
        end
    endtask

    task automatic test_error();
        logic [15:0] frozen, p;
        int          bc;
        bit          ok;
        frozen = 16'(model_partial(64'h3C, 64'hA5, 8, 4, 2));
        if8.dataa = 8'h3C;
        if8.datab = 8'hA5;
        if8.start = 1'b1;
        cyc();
        if8.start = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (if8.step_out !== 2'd2 || status8() !== ST_CALC) begin
            n_fail++;
            $display("FAIL err_setup: step=%0d status=%b required step=2 status=%b",
                     if8.step_out, status8(), ST_CALC);
        end
        if8.start = 1'b1;
        cyc();
        if8.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (status8() !== ST_ERR || if8.product !== frozen || if8.step_out !== 2'd2) begin
                n_fail++;
                $display("FAIL err_hold[%0d]: status=%b product=%h step=%0d required status=%b product=%h step=2",
                         k, status8(), if8.product, if8.step_out, ST_ERR, frozen);
            end
            cyc();
        end
        run_op8(8'h02, 8'h03, 1'b0, p, bc, ok);
        n_checks++;
        if (!ok || p !== 16'h0006) begin
            n_fail++;
            $display("FAIL err_restart: product=%h done_seen=%0d required 0006", p, ok);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        int          bc;
        bit          ok;
        run_op8(8'h80, 8'h80, 1'b0, p, bc, ok);
        n_checks++;
        if (!ok || p !== 16'h4000) begin
            n_fail++;
            $display("FAIL b2b_first: product=%h done_seen=%0d required 4000", p, ok);
        end
        if8.dataa = 8'h07;
        if8.datab = 8'h09;
        if8.start = 1'b1;
        cyc();
        if8.start = 1'b0;
        n_checks++;
        if (status8() !== ST_CALC || if8.step_out !== 2'd0 || if8.product !== 16'h0) begin
            n_fail++;
            $display("FAIL b2b_reenter: status=%b step=%0d product=%h required status=%b step=0 product=0",
                     status8(), if8.step_out, if8.product, ST_CALC);
        end
        wait_done8(1'b1, bc, ok);
        n_checks++;
        if (!ok || if8.product !== 16'h003F || bc != 4) begin
            n_fail++;
            $display("FAIL b2b_second: product=%h busy=%0d done_seen=%0d required 003f busy=4",
                     if8.product, bc, ok);
        end
        cyc();
    endtask

    task automatic test_abort();
        if8.dataa = 8'hFF;
        if8.datab = 8'hFF;
        if8.start = 1'b1;
        cyc();
        if8.start = 1'b0;
        cyc();
        n_checks++;
        if (if8.step_out !== 2'd1 || status8() !== ST_CALC) begin
            n_fail++;
            $display("FAIL abort_setup: step=%0d status=%b required step=1 status=%b",
                     if8.step_out, status8(), ST_CALC);
        end
        if8.abort = 1'b1;
        cyc();
        if8.abort = 1'b0;
        n_checks++;
        if (status8() !== ST_IDLE || if8.product !== 16'h0 || if8.step_out !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_calc: status=%b product=%h step=%0d required status=%b product=0 step=0",
                     status8(), if8.product, if8.step_out, ST_IDLE);
        end
        if8.abort = 1'b1;
        if8.start = 1'b1;
        cyc();
        if8.abort = 1'b0;
        if8.start = 1'b0;
        cyc();
        n_checks++;
        if (status8() !== ST_IDLE || if8.product !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_over_start: status=%b product=%h required status=%b product=0",
                     status8(), if8.product, ST_IDLE);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] p;
        int          bc;
        bit          ok;
        if8.dataa = 8'hFF;
        if8.datab = 8'hFF;
        if8.start = 1'b1;
        cyc();
        if8.start = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (if8.step_out !== 2'd2 || if8.product !== 16'(model_partial(64'hFF, 64'hFF, 8, 4, 2))) begin
            n_fail++;
            $display("FAIL areset_setup: step=%0d product=%h required step=2 product=%h",
                     if8.step_out, if8.product, 16'(model_partial(64'hFF, 64'hFF, 8, 4, 2)));
        end
        #2 reset_a = 1'b0;
        #1;
        n_checks++;
        if (status8() !== ST_IDLE || if8.product !== 16'h0 || if8.step_out !== 2'd0) begin
            n_fail++;
            $display("FAIL areset_now: status=%b product=%h step=%0d required status=%b product=0 step=0",
                     status8(), if8.product, if8.step_out, ST_IDLE);
        end
        #1 reset_a = 1'b1;
        cyc();
        run_op8(8'h0F, 8'h0F, 1'b0, p, bc, ok);
        n_checks++;
        if (!ok || p !== 16'h00E1) begin
            n_fail++;
            $display("FAIL areset_after: product=%h done_seen=%0d required 00e1", p, ok);
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_a    = 1'b0;
        if8.start  = 1'b0;
        if8.abort  = 1'b0;
        if8.dataa  = '0;
        if8.datab  = '0;
        if16.start = 1'b0;
        if16.abort = 1'b0;
        if16.dataa = '0;
        if16.datab = '0;
        cyc();
        cyc();
        test_reset();
        reset_a = 1'b1;
        cyc();
        test_basic();
        test_random8();
        test_wide();
        test_error();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
